// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the operand source, the ALU and the result consumer.
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             use_acc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] f_hi;
  logic             a_bigger;
  logic             b_bigger;
  logic             a_equal_b;
  logic             flag_zero;
  logic             carry_out;
  logic             over_flow;

  modport slave (
    input  in_valid, op, use_acc, a, b, acc_clr, out_ready,
    output in_ready, out_valid, f, f_hi, a_bigger, b_bigger, a_equal_b,
           flag_zero, carry_out, over_flow
  );

  modport master (
    output in_valid, op, use_acc, a, b, acc_clr, out_ready,
    input  in_ready, out_valid, f, f_hi, a_bigger, b_bigger, a_equal_b,
           flag_zero, carry_out, over_flow
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: loads on start_i, one partial product per cycle for WIDTH cycles.
// done_o marks the last iteration; prod_o is the product that iteration produces.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_step;

  // Multiplier sits in the low half and shifts out LSB-first as the high half accumulates.
  always_comb begin
    sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {sum, prod_q[WIDTH-1:1]};
    done_o    = busy_q && (cnt_q == CW'(WIDTH - 1));
    prod_o    = prod_step;
  end

  always_comb begin
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    if (start_i) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      mcand_d = a_i;
      prod_d  = {{WIDTH{1'b0}}, b_i};
    end else if (busy_q) begin
      prod_d = prod_step;
      if (done_o) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: one op in flight, 1-cycle simple ops, WIDTH-cycle MUL, result held until taken.
// Accumulator chains results; a new op is taken in DONE in the same edge the result is consumed.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  state_e             state_q, state_d;
  logic               load, res_we;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, eff_a;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   f_q, f_hi_q;
  logic               a_big_q, b_big_q, eq_q, zero_q, cout_q, ovf_q;
  logic [WIDTH:0]     add_w, sub_w;
  logic [WIDTH-1:0]   res_f, res_hi;
  logic               res_c, res_v;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign eff_a        = bus.use_acc ? acc_q : bus.a;
  assign bus.in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (load && (bus.op == OP_MUL)),
    .a_i     (eff_a),
    .b_i     (bus.b),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    res_we  = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.in_valid) begin
        load    = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: if ((op_q != OP_MUL) || mul_done) begin
        res_we  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: if (bus.out_ready) begin
        load    = bus.in_valid;
        state_d = bus.in_valid ? ST_EXEC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    add_w  = {1'b0, a_q} + {1'b0, b_q};
    sub_w  = {1'b0, a_q} - {1'b0, b_q};
    res_f  = '0;
    res_hi = '0;
    res_c  = 1'b0;
    res_v  = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_f = add_w[MSB:0];
        res_c = add_w[WIDTH];
        res_v = (a_q[MSB] == b_q[MSB]) && (res_f[MSB] != a_q[MSB]);
      end
      OP_SUB, OP_CMP: begin
        res_f = sub_w[MSB:0];
        res_c = ~sub_w[WIDTH];
        res_v = (a_q[MSB] != b_q[MSB]) && (res_f[MSB] != a_q[MSB]);
      end
      OP_AND: res_f = a_q & b_q;
      OP_OR:  res_f = a_q | b_q;
      OP_XOR: res_f = a_q ^ b_q;
      OP_SHL: begin
        res_f = {a_q[MSB-1:0], 1'b0};
        res_c = a_q[MSB];
        res_v = a_q[MSB] ^ a_q[MSB-1];
      end
      OP_MUL: begin
        {res_hi, res_f} = mul_prod;
        res_c = |res_hi;
        res_v = |res_hi;
      end
      default: res_f = '0;
    endcase
  end

  // A result write beats a simultaneous clear; CMP never touches the accumulator.
  always_comb begin
    acc_d = acc_q;
    if (res_we && (op_q != OP_CMP)) acc_d = res_f;
    else if (bus.acc_clr)           acc_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      f_q     <= '0;
      f_hi_q  <= '0;
      a_big_q <= 1'b0;
      b_big_q <= 1'b0;
      eq_q    <= 1'b0;
      zero_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (load) begin
        op_q <= bus.op;
        a_q  <= eff_a;
        b_q  <= bus.b;
      end
      if (res_we) begin
        f_q     <= res_f;
        f_hi_q  <= res_hi;
        a_big_q <= a_q > b_q;
        b_big_q <= a_q < b_q;
        eq_q    <= a_q == b_q;
        zero_q  <= res_f == '0;
        cout_q  <= res_c;
        ovf_q   <= res_v;
      end
    end
  end

  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.f         = f_q;
  assign bus.f_hi      = f_hi_q;
  assign bus.a_bigger  = a_big_q;
  assign bus.b_bigger  = b_big_q;
  assign bus.a_equal_b = eq_q;
  assign bus.flag_zero = zero_q;
  assign bus.carry_out = cout_q;
  assign bus.over_flow = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] f;
    logic [7:0] f_hi;
    logic       cout;
    logic       ovf;
    logic       zero;
    logic       ab;
    logic       bb;
    logic       eq;
  } res_t;

  int         total = 0;
  int         bad = 0;
  logic [7:0] acc_m = 8'h00;

  function automatic res_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    res_t r;
    int ua, ub, sa, sb, x;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    r = '0;
    case (op)
      OP_ADD: begin
        x = ua + ub; r.f = 8'(x); r.cout = (x > 255);
        r.ovf = (sa + sb > 127) || (sa + sb < -128);
      end
      OP_SUB, OP_CMP: begin
        x = ua - ub; r.f = 8'(x); r.cout = (ua >= ub);
        r.ovf = (sa - sb > 127) || (sa - sb < -128);
      end
      OP_AND: r.f = a & b;
      OP_OR:  r.f = a | b;
      OP_XOR: r.f = a ^ b;
      OP_SHL: begin
        x = ua * 2; r.f = 8'(x); r.cout = (ua >= 128);
        r.ovf = (ua >= 128) != ((ua % 128) >= 64);
      end
      default: begin
        x = ua * ub; r.f = 8'(x); r.f_hi = 8'(x / 256);
        r.cout = (x > 255); r.ovf = (x > 255);
      end
    endcase
    r.zero = (r.f == 8'h00);
    r.ab = ua > ub; r.bb = ua < ub; r.eq = ua == ub;
    return r;
  endfunction

  // Resolves the effective operand and advances the accumulator model.
  function automatic res_t expect_op(input logic [2:0] op, input logic ua, input logic [7:0] a,
                                     input logic [7:0] b);
    res_t r;
    r = model(op, ua ? acc_m : a, b);
    if (op != OP_CMP) acc_m = r.f;
    return r;
  endfunction

  function automatic res_t observe();
    res_t r;
    r = {bus.f, bus.f_hi, bus.carry_out, bus.over_flow, bus.flag_zero,
         bus.a_bigger, bus.b_bigger, bus.a_equal_b};
    return r;
  endfunction

  task automatic set_op(input logic [2:0] op, input logic ua, input logic [7:0] a, input logic [7:0] b);
    bus.op = op; bus.use_acc = ua; bus.a = a; bus.b = b;
  endtask

  // Issues one op, waits for its result and leaves it sitting in DONE.
  task automatic run_op(input logic [2:0] op, input logic ua, input logic [7:0] a, input logic [7:0] b,
                        output res_t obs, output int lat);
    int n;
    n = 0;
    set_op(op, ua, a, b);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    while (!bus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    obs = observe();
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.acc_clr = 1'b1;
    @(posedge clk); #1;
    bus.acc_clr = 1'b0;
    acc_m = 8'h00;
  endtask

  task automatic test_reset();
    res_t obs;
    #2;
    obs = observe();
    total++;
    if (obs !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset got=%h ov=%b ir=%b want=0 ov=0 ir=1", obs, bus.out_valid, bus.in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub_cmp();
    res_t obs, exp;
    int lat;
    exp = expect_op(OP_ADD, 1'b0, 8'hFF, 8'hAA);
    run_op(OP_ADD, 1'b0, 8'hFF, 8'hAA, obs, lat);
    total++;
    if (obs !== exp || lat !== 1 || obs.f !== 8'hA9 || obs.cout !== 1'b1 || obs.ab !== 1'b1) begin
      bad++; $display("FAIL add_ffaa got=%h lat=%0d want=%h lat=1", obs, lat, exp);
    end
    consume();
    exp = expect_op(OP_SUB, 1'b0, 8'hFF, 8'hFF);
    run_op(OP_SUB, 1'b0, 8'hFF, 8'hFF, obs, lat);
    total++;
    if (obs !== exp || obs.zero !== 1'b1 || obs.eq !== 1'b1 || obs.cout !== 1'b1) begin
      bad++; $display("FAIL sub_ffff got=%h want=%h", obs, exp);
    end
    consume();
    exp = expect_op(OP_CMP, 1'b0, 8'h55, 8'hCC);
    run_op(OP_CMP, 1'b0, 8'h55, 8'hCC, obs, lat);
    total++;
    if (obs !== exp || obs.bb !== 1'b1 || obs.cout !== 1'b0) begin
      bad++; $display("FAIL cmp_55cc got=%h want=%h", obs, exp);
    end
    consume();
    exp = expect_op(OP_ADD, 1'b1, 8'h77, 8'h00);
    run_op(OP_ADD, 1'b1, 8'h77, 8'h00, obs, lat);
    total++;
    if (obs !== exp || obs.f !== 8'h00) begin
      bad++; $display("FAIL acc_after_cmp got=%h want=%h", obs, exp);
    end
    consume();
  endtask

  task automatic test_mul();
    res_t obs, exp;
    int lat;
    exp = expect_op(OP_MUL, 1'b0, 8'h55, 8'hCC);
    run_op(OP_MUL, 1'b0, 8'h55, 8'hCC, obs, lat);
    total++;
    if (obs !== exp || lat !== 8 || {obs.f_hi, obs.f} !== 16'h43BC || obs.cout !== 1'b1 || obs.ovf !== 1'b1) begin
      bad++; $display("FAIL mul_55cc got=%h lat=%0d want=%h lat=8", obs, lat, exp);
    end
    consume();
  endtask

  task automatic test_chain();
    res_t obs, exp;
    int lat;
    exp = expect_op(OP_ADD, 1'b0, 8'h10, 8'h05);
    run_op(OP_ADD, 1'b0, 8'h10, 8'h05, obs, lat);
    total++;
    if (obs !== exp || obs.f !== 8'h15) begin bad++; $display("FAIL chain0 got=%h want=%h", obs, exp); end
    consume();
    exp = expect_op(OP_ADD, 1'b1, 8'hEE, 8'h01);
    run_op(OP_ADD, 1'b1, 8'hEE, 8'h01, obs, lat);
    total++;
    if (obs !== exp || obs.f !== 8'h16) begin bad++; $display("FAIL chain1 got=%h want=%h", obs, exp); end
    consume();
    pulse_clr();
    exp = expect_op(OP_ADD, 1'b1, 8'hEE, 8'h01);
    run_op(OP_ADD, 1'b1, 8'hEE, 8'h01, obs, lat);
    total++;
    if (obs !== exp || obs.f !== 8'h01) begin bad++; $display("FAIL chain_clr got=%h want=%h", obs, exp); end
    consume();
  endtask

  task automatic test_backpressure();
    res_t obs, exp, exp2;
    int lat;
    logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom);
    exp = expect_op(OP_XOR, 1'b0, a, b);
    run_op(OP_XOR, 1'b0, a, b, obs, lat);
    a = 8'($urandom); b = 8'($urandom);
    set_op(OP_SUB, 1'b0, a, b);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (observe() !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        bad++; $display("FAIL hold%0d got=%h ov=%b ir=%b want=%h ov=1 ir=0", i, observe(),
                        bus.out_valid, bus.in_ready, exp);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", bus.in_ready); end
    exp2 = expect_op(OP_SUB, 1'b0, a, b);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL direct_accept ov=%b want=0", bus.out_valid); end
    @(posedge clk); #1;
    total++;
    if (bus.out_valid !== 1'b1 || observe() !== exp2) begin
      bad++; $display("FAIL direct_result got=%h ov=%b want=%h", observe(), bus.out_valid, exp2);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    res_t q[$];
    res_t exp;
    logic [2:0] ops[N];
    logic       uas[N];
    logic [7:0] as[N], bs[N];
    int k, got, first, last;
    logic accepted;
    for (int i = 0; i < N; i++) begin
      ops[i] = 3'($urandom_range(0, 6)); uas[i] = 1'($urandom);
      as[i] = 8'($urandom); bs[i] = 8'($urandom);
    end
    k = 0; got = 0; first = -1; last = 0;
    set_op(ops[0], uas[0], as[0], bs[0]);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got < N; cyc++) begin
      if (bus.out_valid) begin
        total++;
        exp = (q.size() > 0) ? q.pop_front() : '0;
        if (observe() !== exp) begin bad++; $display("FAIL b2b%0d got=%h want=%h", got, observe(), exp); end
        got++; last = cyc;
      end
      accepted = bus.in_valid && bus.in_ready;
      if (accepted) begin
        q.push_back(expect_op(ops[k], uas[k], as[k], bs[k]));
        if (first < 0) first = cyc;
      end
      @(posedge clk); #1;
      if (accepted) begin
        k++;
        if (k < N) set_op(ops[k], uas[k], as[k], bs[k]);
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    total++;
    if (got !== N || (last - first) !== 2 * N) begin
      bad++; $display("FAIL b2b_rate results=%0d span=%0d want %0d/%0d", got, last - first, N, 2 * N);
    end
  endtask

  task automatic test_random();
    res_t obs, exp;
    int lat;
    logic [2:0] op;
    logic ua;
    logic [7:0] a, b;
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 4) == 0) pulse_clr();
      op = 3'($urandom); ua = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      exp = expect_op(op, ua, a, b);
      run_op(op, ua, a, b, obs, lat);
      total++;
      if (obs !== exp || lat !== ((op == OP_MUL) ? 8 : 1)) begin
        bad++; $display("FAIL rand%0d op=%0d got=%h lat=%0d want=%h", i, op, obs, lat, exp);
      end
      consume();
    end
  endtask

  task automatic test_reset_abort();
    res_t obs, exp;
    int lat, seen;
    set_op(OP_MUL, 1'b0, 8'hFF, 8'hFF);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (observe() !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL abort_reset got=%h ov=%b ir=%b want=0 ov=0 ir=1", observe(),
                      bus.out_valid, bus.in_ready);
    end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    acc_m = 8'h00;
    seen = 0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL abort_no_valid got=%0d want=0", seen); end
    exp = expect_op(OP_ADD, 1'b0, 8'h01, 8'h01);
    run_op(OP_ADD, 1'b0, 8'h01, 8'h01, obs, lat);
    total++;
    if (obs !== exp || obs.f !== 8'h02) begin bad++; $display("FAIL after_abort got=%h want=%h", obs, exp); end
    consume();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.acc_clr = 1'b0;
    set_op(OP_ADD, 1'b0, 8'h00, 8'h00);
    test_reset();
    test_add_sub_cmp();
    test_mul();
    test_chain();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 8-bit structural ALU. Accepts one operation at a time over a valid/ready interface, executes simple ops in one cycle and a shift-add multiply in WIDTH cycles, and holds a registered result with flags until the consumer takes it. An internal accumulator lets back-to-back ops chain without re-supplying operand A. It sits between the instruction/operand source and the result bus of the datapath.

## Interface
Parameters:
- WIDTH, 8: operand/result width, at least 4.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  operation request valid.
- IN_READY  out  1  block can accept; equals (state==IDLE) || (state==DONE && OUT_READY). Combinational path from OUT_READY.
- OP  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 CMP, 110 SHL, 111 MUL.
- USE_ACC  in  1  if 1, the accumulator replaces A as the first operand.
- A, B  in  WIDTH  operands.
- ACC_CLR  in  1  synchronous accumulator clear.
- OUT_VALID  out  1  result/flags valid; high only in DONE.
- OUT_READY  in  1  consumer accepts the result.
- F  out  WIDTH  result (low half for MUL).
- F_HI  out  WIDTH  MUL high half; 0 for every other op.
- A_BIGGER, B_BIGGER, A_EQUAL_B  out  1  unsigned compare of the effective operands.
- FLAG_ZERO, CARRY_OUT, OVER_FLOW  out  1  status flags.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: on IN_VALID, latch OP, effective A (ACC if USE_ACC else A), B; go to EXEC.
- EXEC, non-MUL: compute, register F/F_HI/flags; go to DONE.
- EXEC, MUL: run the shift-add multiplier for WIDTH cycles; on the last cycle register the result; go to DONE.
- DONE: hold all outputs stable. On OUT_READY: if IN_VALID, accept the new op (as from IDLE) and go to EXEC; otherwise go to IDLE.
- Arithmetic: ADD/SUB are WIDTH-bit modular. CARRY_OUT is the carry for ADD and NOT-borrow (1 when A>=B unsigned) for SUB/CMP. OVER_FLOW is two's-complement signed overflow for ADD/SUB/CMP.
- CMP: F = A-B and flags as SUB; the accumulator is not written.
- AND/OR/XOR: CARRY_OUT=0, OVER_FLOW=0.
- SHL: F = A<<1; CARRY_OUT = A[WIDTH-1]; OVER_FLOW = A[WIDTH-1]^A[WIDTH-2].
- MUL: unsigned 2·WIDTH product, split {F_HI,F}; CARRY_OUT = OVER_FLOW = (F_HI!=0).
- FLAG_ZERO = (F==0). Compare flags are valid for every op; exactly one is 1.
- Accumulator: written with F whenever the result is registered, except for CMP. ACC_CLR clears it at the next edge. If ACC_CLR coincides with a result write, the result write wins. USE_ACC is sampled only at accept.

## Timing
- Reset, asynchronous: state IDLE; ACC, F, F_HI and all flags 0; OUT_VALID 0; multiplier counter 0. IN_READY is 1 during and after reset.
- Latency from the accept edge to OUT_VALID rising edge: 1 cycle for non-MUL ops, WIDTH cycles for MUL.
- Throughput: one op per 2 cycles (non-MUL) with OUT_READY held high, using the DONE→EXEC direct accept.
- Outputs change only on the register edge that enters DONE. Inputs are ignored in EXEC.
- Reset asserted in EXEC or DONE aborts the op. No OUT_VALID is produced for it.
- OUT_VALID never drops without OUT_READY.

## Structure
- Shared package alu_pkg: opcode localparams (OP_ADD…OP_MUL), FSM state encoding.
- Sub-module alu_mul_seq(WIDTH): shift-add multiplier with start/done, a clog2(WIDTH)-bit counter and a 2·WIDTH product register. Top instantiates it; all other ops are inline.

## Test plan
- WIDTH=8, ADD A=FF B=AA -> after 1 cycle: F=A9, CARRY_OUT=1, OVER_FLOW=0, A_BIGGER=1, FLAG_ZERO=0.
- SUB A=FF B=FF -> F=00, FLAG_ZERO=1, A_EQUAL_B=1, CARRY_OUT=1; then CMP A=55 B=CC -> B_BIGGER=1, CARRY_OUT=0, and ACC still 00.
- MUL A=55 B=CC -> OUT_VALID exactly 8 cycles after accept: F=BC, F_HI=43, CARRY_OUT=1, OVER_FLOW=1.
- Chain ADD A=10 B=05, then ADD USE_ACC=1 B=01 -> F=15, then F=16. ACC_CLR pulse -> next ADD USE_ACC=1 B=01 gives 01.
- Backpressure: hold OUT_READY=0 for 5 cycles in DONE -> outputs stable, IN_READY=0. Raise OUT_READY with IN_VALID=1 -> new op accepted that edge.
- Assert RST_N=0 at cycle 4 of a MUL -> all outputs 0, IN_READY=1, no OUT_VALID for the aborted op. Next ADD 01+01 -> F=02.
